ysyx_24100005_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24100005_mem_arbiter
// PURPOSE
//  Shares the core's single memory port (DPI npcmem_read/npcmem_write bridge) between the IFU and the LSU.
//  Accepts one request at a time, forwards it to memory and routes the response back to its requester.
//  Only one transaction is outstanding at any time.
//  Sits between the fetch/load-store units and the memory bridge; enables the move to a multi-cycle core.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  MASK_W       8   write byte-mask width (matches npcmem_write wmask)
//  LSU_RUN_MAX  4   max consecutive LSU grants while IFU waits; range 1..15
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  ifu_valid      in   1       IFU request valid (read only)
//  ifu_ready      out  1       IFU request accepted this cycle
//  ifu_addr       in   ADDR_W  IFU fetch address
//  ifu_rvalid     out  1       IFU response valid (1-cycle pulse)
//  ifu_rdata      out  DATA_W  IFU response data
//  lsu_valid      in   1       LSU request valid
//  lsu_ready      out  1       LSU request accepted this cycle
//  lsu_addr       in   ADDR_W  LSU address
//  lsu_wen        in   1       1 = store, 0 = load
//  lsu_wdata      in   DATA_W  store data
//  lsu_wmask      in   MASK_W  store byte mask
//  lsu_rvalid     out  1       LSU response valid (1-cycle pulse; also acks stores)
//  lsu_rdata      out  DATA_W  LSU load data
//  mem_valid      out  1       request to memory bridge
//  mem_ready      in   1       bridge accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  registered request fields
//  mem_rvalid     in   1       bridge response valid
//  mem_rdata      in   DATA_W  bridge response data
//  err_spurious   out  1       pulse: mem_rvalid seen outside WAIT
// BEHAVIOUR
//  Reset: state=IDLE, grant=IFU, run_cnt=0; all valid/ready/err outputs 0; mem_* fields 0.
//  FSM IDLE -> REQ -> WAIT -> IDLE.
//  IDLE:
//   - If any request is valid, arbitrate and pulse the winner's *_ready (combinational, same cycle).
//   - Latch the winner's addr/wen/wdata/wmask and the grant; go to REQ.
//   - IFU requests are latched with wen=0, wmask=0, wdata=0.
//  Arbitration: LSU has priority, except when ifu_valid && run_cnt==LSU_RUN_MAX, then IFU wins.
//   - run_cnt increments on each LSU grant while ifu_valid=1; clears on any IFU grant.
//   - run_cnt saturates at LSU_RUN_MAX.
//  REQ: mem_valid=1 with the latched fields held stable; mem_ready=1 -> WAIT (same-edge).
//   - mem_valid must not drop until mem_ready.
//  WAIT: mem_rvalid=1 -> drive the granted *_rvalid=1 and *_rdata=mem_rdata combinationally; -> IDLE.
//   - Non-granted rvalid stays 0; *_rdata is 0 when its rvalid is 0.
//   - Stores also wait for mem_rvalid (write ack).
//  Latency: accept at cycle N; mem_valid at N+1; earliest response at N+2 (0-wait bridge).
//   - Back-to-back acceptance no earlier than the cycle after the response.
//  mem_rvalid in IDLE/REQ: ignored (no routing); err_spurious=1 that cycle.
//  Simultaneous response and new request in WAIT: the request is not accepted until IDLE (next cycle).
//  Reset mid-transaction: return to IDLE, outstanding transaction is dropped, no rvalid.
//   - The bridge shares rst.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT=2'd2), GNT_IFU=0/GNT_LSU=1.
//  Shared constants: reset-value constants for mem_*.
//  One sub-module: ysyx_24100005_mem_arb_pick.
//   - Combinational priority plus starvation counter compare; inputs ifu_valid, lsu_valid, run_cnt; outputs gnt, any.
//  FSM, request registers and response mux live in the top.
// TESTING
//  1 IFU-only path: ifu_valid=1, addr=0x80000000, bridge 0-wait with rdata=0x00100073.
//   - Expect ifu_ready at cycle 0, mem_valid at cycle 1 with addr 0x80000000.
//   - Expect ifu_rvalid=1 with rdata 0x00100073 at cycle 2.
//  2 Store path: lsu store addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F.
//   - Expect mem_wen=1 and the same fields on mem_*; lsu_rvalid pulse on ack; ifu_rvalid stays 0.
//  3 Contention: both requesters valid continuously, LSU_RUN_MAX=4.
//   - Expect grant order LSU,LSU,LSU,LSU,IFU, repeating; no starvation.
//  4 Bridge stall: mem_ready low for 3 cycles, then mem_rvalid 5 cycles later.
//   - Expect mem_* held stable throughout and a single rvalid pulse.
//  5 Reset in WAIT: assert rst for 1 cycle.
//   - Expect state IDLE, all outputs 0, and no rvalid even if mem_rvalid arrives afterward.
//   - The late mem_rvalid must pulse err_spurious.
//  6 Spurious response: mem_rvalid=1 while in IDLE.
//   - Expect err_spurious=1 for one cycle and no ifu/lsu rvalid.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter_pkg.sv
// rtl/ysyx_24100005_mem_arbiter_pkg.sv - shared encodings and reset constants for the memory arbiter
package ysyx_24100005_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

    // Reset value of every bit of the registered mem_* request fields.
    localparam logic MEM_FIELD_RST_BIT = 1'b0;
    localparam logic MEM_WEN_RST       = 1'b0;

    // Width of the LSU run counter; holds LSU_RUN_MAX up to 15.
    localparam int RUN_CNT_W = 4;

endpackage

// File: rtl/ysyx_24100005_mem_arb_pick.sv
// rtl/ysyx_24100005_mem_arb_pick.sv - LSU-priority pick with IFU anti-starvation override
module ysyx_24100005_mem_arb_pick
    import ysyx_24100005_mem_arbiter_pkg::*;
#(
    parameter int LSU_RUN_MAX = 4
) (
    input  logic                 ifu_valid,
    input  logic                 lsu_valid,
    input  logic [RUN_CNT_W-1:0] run_cnt,
    output gnt_e                 gnt,
    output logic                 any
);

    // LSU wins unless the IFU has watched LSU_RUN_MAX LSU grants go by.
    always_comb begin
        any = ifu_valid | lsu_valid;
        gnt = GNT_IFU;
        if (lsu_valid && !(ifu_valid && (run_cnt == RUN_CNT_W'(LSU_RUN_MAX)))) begin
            gnt = GNT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// rtl/ysyx_24100005_mem_arbiter.sv - single-outstanding IFU/LSU arbiter in front of the memory bridge
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MASK_W      = 8,
    parameter int LSU_RUN_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_valid,
    output logic              ifu_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_spurious
);

    state_e               state_q, state_d;
    gnt_e                 gnt_q, gnt_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [MASK_W-1:0]    wmask_q, wmask_d;

    gnt_e pick_gnt;
    logic pick_any;

    ysyx_24100005_mem_arb_pick #(
        .LSU_RUN_MAX(LSU_RUN_MAX)
    ) u_pick (
        .ifu_valid(ifu_valid),
        .lsu_valid(lsu_valid),
        .run_cnt  (run_cnt_q),
        .gnt      (pick_gnt),
        .any      (pick_any)
    );

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    // Next-state, request capture, handshakes and response routing; rst masks every strobe.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        run_cnt_d    = run_cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ifu_ready    = 1'b0;
        lsu_ready    = 1'b0;
        ifu_rvalid   = 1'b0;
        lsu_rvalid   = 1'b0;
        ifu_rdata    = '0;
        lsu_rdata    = '0;
        mem_valid    = 1'b0;
        err_spurious = mem_rvalid && (state_q != ST_WAIT) && !rst;

        case (state_q)
            ST_IDLE: begin
                if (pick_any && !rst) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_REQ;
                    if (pick_gnt == GNT_LSU) begin
                        lsu_ready = 1'b1;
                        addr_d    = lsu_addr;
                        wen_d     = lsu_wen;
                        wdata_d   = lsu_wdata;
                        wmask_d   = lsu_wmask;
                        if (ifu_valid && (run_cnt_q != RUN_CNT_W'(LSU_RUN_MAX))) begin
                            run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                        end
                    end else begin
                        ifu_ready = 1'b1;
                        addr_d    = ifu_addr;
                        wen_d     = 1'b0;
                        wdata_d   = '0;
                        wmask_d   = '0;
                        run_cnt_d = '0;
                    end
                end
            end
            ST_REQ: begin
                mem_valid = !rst;
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid && !rst) begin
                    state_d = ST_IDLE;
                    if (gnt_q == GNT_LSU) begin
                        lsu_rvalid = 1'b1;
                        lsu_rdata  = mem_rdata;
                    end else begin
                        ifu_rvalid = 1'b1;
                        ifu_rdata  = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset drops any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_IFU;
            run_cnt_q <= '0;
            addr_q    <= {ADDR_W{MEM_FIELD_RST_BIT}};
            wen_q     <= MEM_WEN_RST;
            wdata_q   <= {DATA_W{MEM_FIELD_RST_BIT}};
            wmask_q   <= {MASK_W{MEM_FIELD_RST_BIT}};
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            run_cnt_q <= run_cnt_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb/tb_ysyx_24100005_mem_arbiter.sv - self-checking bench for the IFU/LSU memory arbiter
module tb_ysyx_24100005_mem_arbiter;

    localparam int RUN_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid, ifu_ready, ifu_rvalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_valid, lsu_ready, lsu_wen, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid, err_spurious;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    int rc = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MASK_W(8), .LSU_RUN_MAX(RUN_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_spurious(err_spurious)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference arbitration: 1 = LSU wins.
    function automatic bit model_pick(input bit iv, input bit lv);
        if (lv && !(iv && rc == RUN_MAX)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_update(input bit iv, input bit g);
        if (!g) rc = 0;
        else if (iv) rc = (rc + 1 > RUN_MAX) ? RUN_MAX : rc + 1;
    endfunction

    // One complete transaction from IDLE, with sr request-stall and sw response-wait cycles.
    task automatic transact(input bit iv, input bit lv, input bit lw,
                            input logic [31:0] ia, input logic [31:0] la,
                            input logic [31:0] wd, input logic [7:0] wm,
                            input logic [31:0] rd, input int sr, input int sw,
                            output bit g);
        logic [31:0] ea, ed;
        logic [7:0]  em;
        logic        ew;
        logic        sp;
        ifu_valid = iv; ifu_addr = ia;
        lsu_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = wd; lsu_wmask = wm;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        g = model_pick(iv, lv);
        #1;
        chk("accept_ifu_ready", ifu_ready, !g);
        chk("accept_lsu_ready", lsu_ready, g);
        chk("accept_mem_valid", mem_valid, 1'b0);
        model_update(iv, g);
        ea = g ? la : ia;
        ew = g ? lw : 1'b0;
        ed = g ? wd : 32'h0;
        em = g ? wm : 8'h0;
        step();
        for (int k = 0; k < sr; k++) begin
            sp = 1'($urandom_range(0, 1));
            mem_ready = 1'b0; mem_rvalid = sp;
            ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
            lsu_wmask = $urandom; lsu_wen = $urandom;
            #1;
            chk("stall_mem_valid", mem_valid, 1'b1);
            chk("stall_mem_fields", {mem_addr, mem_wdata}, {ea, ed});
            chk("stall_mem_ctl", {mem_wen, mem_wmask}, {ew, em});
            chk("stall_err_spurious", err_spurious, sp);
            chk("stall_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
            chk("stall_readies", {ifu_ready, lsu_ready}, 2'b00);
            step();
        end
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        #1;
        chk("req_mem_valid", mem_valid, 1'b1);
        chk("req_mem_fields", {mem_addr, mem_wdata}, {ea, ed});
        chk("req_mem_ctl", {mem_wen, mem_wmask}, {ew, em});
        step();
        mem_ready = 1'b0;
        for (int k = 0; k < sw; k++) begin
            #1;
            chk("wait_mem_valid", mem_valid, 1'b0);
            chk("wait_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
            chk("wait_readies", {ifu_ready, lsu_ready}, 2'b00);
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = rd;
        #1;
        chk("resp_ifu_rvalid", ifu_rvalid, !g);
        chk("resp_lsu_rvalid", lsu_rvalid, g);
        chk("resp_ifu_rdata", ifu_rdata, g ? 32'h0 : rd);
        chk("resp_lsu_rdata", lsu_rdata, g ? rd : 32'h0);
        chk("resp_readies", {ifu_ready, lsu_ready}, 2'b00);
        chk("resp_err_spurious", err_spurious, 1'b0);
        step();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1;
        chk("post_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        chk("post_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
    endtask

    initial begin
        bit g;
        bit iv, lv;
        rst = 1'b1;
        ifu_valid = 1'b1; ifu_addr = 32'h1234; lsu_valid = 1'b1; lsu_addr = 32'h5678;
        lsu_wen = 1'b1; lsu_wdata = 32'h9; lsu_wmask = 8'hFF;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        #1;
        chk("rst_readies", {ifu_ready, lsu_ready}, 2'b00);
        chk("rst_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_err_spurious", err_spurious, 1'b0);
        chk("rst_mem_fields", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_mem_ctl", {mem_wen, mem_wmask}, 9'h0);
        ifu_valid = 1'b0; lsu_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // IFU-only fetch with a 0-wait bridge.
        transact(1, 0, 0, 32'h80000000, 32'h0, 32'h0, 8'h0, 32'h00100073, 0, 0, g);
        chk("ifu_only_gnt", g, 1'b0);
        ifu_valid = 1'b0;

        // Store path.
        transact(0, 1, 1, 32'h0, 32'h80001000, 32'hDEADBEEF, 8'h0F, $urandom, 0, 1, g);
        chk("store_gnt", g, 1'b1);
        lsu_valid = 1'b0;

        // Continuous contention: four LSU grants then one IFU grant, repeating.
        for (int i = 0; i < 10; i++) begin
            transact(1, 1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                     $urandom, 0, 0, g);
            chk("contention_gnt", g, (i % 5 == 4) ? 1'b0 : 1'b1);
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;

        // Bridge stall: mem_ready low 3 cycles, response 5 cycles later.
        transact(0, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 3, 5, g);
        lsu_valid = 1'b0;

        // Randomized mix checked against the arbitration model.
        for (int i = 0; i < 24; i++) begin
            iv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            if (!iv && !lv) iv = 1'b1;
            transact(iv, lv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), g);
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;

        // Reset while in WAIT; the late response must only raise err_spurious.
        ifu_valid = 1'b1; ifu_addr = 32'h80000040; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("rstwait_accept", ifu_ready, 1'b1);
        step();
        ifu_valid = 1'b0; mem_ready = 1'b1;
        step();
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        chk("rstwait_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        chk("rstwait_mem_valid", mem_valid, 1'b0);
        step();
        rst = 1'b0; rc = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("late_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        chk("late_err_spurious", err_spurious, 1'b1);
        chk("late_mem_valid", mem_valid, 1'b0);
        chk("late_mem_addr", mem_addr, 32'h0);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk("late_err_clear", err_spurious, 1'b0);
        step();

        // Spurious response while idle.
        mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        #1;
        chk("idle_err_spurious", err_spurious, 1'b1);
        chk("idle_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        chk("idle_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk("idle_err_clear", err_spurious, 1'b0);

        // Arbiter still works after the error cases.
        transact(1, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 0, g);
        chk("final_gnt", g, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
